cr_cceip_64_sa_drain: RTL and testbench
=======================================

Name: cr_cceip_64_sa_drain

Overview:
- Downstream consumer of the 64-counter stats aggregator.
- On a software or firmware drain request, it pulses the aggregator's snapshot strobe and waits for the snapshot to settle.
- It then streams each enabled 50-bit snapshot counter out as one 64-bit beat on a valid/ready interface toward the stats export path.
- A beat carries the module id, the counter index and the counter value.

Parameters:
- N_CNT, 64, number of counters; index width is log2(N_CNT) = 6.
- CNT_W, 50, snapshot counter width.
- MID_W, 8, module id field width; MID_W + 6 + CNT_W must equal 64.
- SNAP_LAT, 2, cycles to wait after sa_snap before snapshot values are valid; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- drain_start  in  1  single-cycle request to start a drain
- drain_mask  in  N_CNT  counters to emit; sampled only when drain_start is accepted
- module_id  in  MID_W  source id placed in every beat
- sa_snapshot  in  N_CNT*CNT_W  flattened snapshot array; counter i occupies bits [i*CNT_W +: CNT_W]
- sa_snap  out  1  one-cycle snapshot strobe to the aggregator
- drain_busy  out  1  high from accepted start through the drain_done cycle
- drain_done  out  1  one-cycle pulse when the drain completes
- start_drop  out  1  one-cycle pulse when drain_start arrives while busy
- out_valid  out  1  beat valid
- out_ready  in  1  consumer ready
- out_data  out  64  {module_id, idx[5:0], value[CNT_W-1:0]}
- out_last  out  1  final beat of this drain

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset: every output is 0. FSM goes to IDLE, remaining mask and wait counter clear. A reset mid-drain abandons it immediately; there is no done pulse and no further beats.
- FSM states: IDLE, SNAP, WAIT, STREAM, DONE.
- IDLE:
  - drain_start=1 latches drain_mask into rem_mask, asserts drain_busy next cycle, and moves to SNAP.
- SNAP:
  - sa_snap=1 for exactly this cycle.
  - wait_cnt is loaded with SNAP_LAT-1; go to WAIT.
- WAIT:
  - Decrement wait_cnt each cycle; at 0 go to STREAM.
  - From accepted start, the first beat therefore appears no earlier than cycle 2+SNAP_LAT.
- STREAM:
  - The output register is a single-entry skid-free stage. It loads when (!out_valid || out_ready) && rem_mask != 0.
  - The loaded beat uses idx = lowest set bit of rem_mask; that bit clears in the same cycle.
  - out_last=1 when rem_mask after clearing is 0.
  - If no load occurs but out_valid && out_ready, then out_valid drops.
  - Sustained throughput is 1 beat/cycle while out_ready=1.
  - out_data, out_last and out_valid hold stable while out_valid && !out_ready.
  - Once rem_mask == 0 and no beat is pending (out_valid=0, or the last beat is accepted this cycle), go to DONE.
- DONE:
  - drain_done=1 for one cycle; drain_busy is still 1 in this cycle.
  - Next cycle is IDLE with busy=0.
- Empty mask: the FSM still goes SNAP→WAIT→STREAM→DONE, with zero beats and one done pulse.
- drain_start in any state other than IDLE is ignored and start_drop pulses the same cycle. A start in the DONE cycle is also dropped.
- Beats are emitted in ascending index order.
- Values are sampled from sa_snapshot at load time. The snapshot is stable because only this block issues sa_snap.

Optional Feature:
- Macro: CR_CCEIP_64_SA_DRAIN_SKIP_ZERO_EN.
- Defined:
  - Counters whose snapshot value is 0 are skipped.
  - Selection uses eff_mask = rem_mask & nz_vec, where nz_vec[i] = |value_i.
  - On any load, unselected zero bits below idx are also cleared. If eff_mask==0 in STREAM, rem_mask clears in one cycle.
  - out_last is computed against eff_mask after clearing.
  - A drain whose enabled counters are all zero produces no beats.
- Undefined: every enabled counter is emitted regardless of value.

Decomposition:
- Shared package cr_cceip_64_sa_drainPKG holds:
  - enum sa_drain_state_e {IDLE, SNAP, WAIT, STREAM, DONE};
  - packed struct sa_drain_beat_t {mid, idx, value};
  - constants SA_DRAIN_IDX_W=6 and SA_DRAIN_BEAT_W=64.
- One sub-module is natural: cr_cceip_64_sa_drain_pri, a parameterised lowest-set-bit finder returning idx, found, and the mask-with-bit-cleared.

Test Plan:
- Mask=64'h1, snapshot[0]=50'h3_FFFF_FFFF_FFFF, module_id=8'hA5, out_ready=1 → sa_snap pulses cycle 1; one beat out_data={8'hA5,6'd0,value}, out_last=1; drain_done one cycle after acceptance.
- Mask=64'h8000_0000_0000_0011, ready=1 → beats at idx 0, 4, 63 in consecutive cycles; out_last only on idx 63.
- Same mask, out_ready toggling 0/1 every cycle → each beat held stable while stalled, no drop or duplicate, 3 beats total.
- Mask=0 → sa_snap pulses, no out_valid, drain_done once, busy width = 2+SNAP_LAT+1 cycles.
- drain_start reasserted during STREAM → start_drop pulses, current drain unaffected; rst asserted mid-stream → all outputs 0 next cycle and a new drain restarts cleanly.
- With CR_CCEIP_64_SA_DRAIN_SKIP_ZERO_EN: mask=64'hF, values {0,5,0,7} → beats idx 1 and 3 only, out_last on idx 3.

Source files
------------

// File: rtl/cr_cceip_64_sa_drain_pkg.sv
// Shared types and constants for the stats aggregator drain block.
// Optional feature macro used by the block: CR_CCEIP_64_SA_DRAIN_SKIP_ZERO_EN.
package cr_cceip_64_sa_drain_pkg;

  localparam int SA_DRAIN_N_CNT   = 64;
  localparam int SA_DRAIN_CNT_W   = 50;
  localparam int SA_DRAIN_MID_W   = 8;
  localparam int SA_DRAIN_IDX_W   = 6;
  localparam int SA_DRAIN_BEAT_W  = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SNAP   = 3'd1,
    WAIT   = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } sa_drain_state_e;

  typedef struct packed {
    logic [SA_DRAIN_MID_W-1:0] mid;
    logic [SA_DRAIN_IDX_W-1:0] idx;
    logic [SA_DRAIN_CNT_W-1:0] value;
  } sa_drain_beat_t;

endpackage

// File: rtl/cr_cceip_64_sa_drain_pri.sv
// Lowest-set-bit finder: index of the lowest 1, a found flag, and the mask
// with that bit cleared.
module cr_cceip_64_sa_drain_pri #(
  parameter int W = 64
) (
  input  logic [W-1:0]         mask_i,
  output logic [$clog2(W)-1:0] idx_o,
  output logic                 found_o,
  output logic [W-1:0]         clr_o
);

  localparam int IW = $clog2(W);

  // Scan from the top down so the last hit is the lowest set bit.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o   = IW'(i);
        found_o = 1'b1;
      end
    end
  end

  assign clr_o = mask_i & (mask_i - W'(1));

endmodule

// File: rtl/cr_cceip_64_sa_drain.sv
// Stats aggregator drain: snapshots the aggregator on request and streams
// every enabled counter out as a 64-bit {module_id, idx, value} beat.
// Optional macro CR_CCEIP_64_SA_DRAIN_SKIP_ZERO_EN skips zero-valued counters.
module cr_cceip_64_sa_drain
  import cr_cceip_64_sa_drain_pkg::*;
#(
  parameter int N_CNT    = SA_DRAIN_N_CNT,
  parameter int CNT_W    = SA_DRAIN_CNT_W,
  parameter int MID_W    = SA_DRAIN_MID_W,
  parameter int SNAP_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   drain_start,
  input  logic [N_CNT-1:0]       drain_mask,
  input  logic [MID_W-1:0]       module_id,
  input  logic [N_CNT*CNT_W-1:0] sa_snapshot,
  output logic                   sa_snap,
  output logic                   drain_busy,
  output logic                   drain_done,
  output logic                   start_drop,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_data,
  output logic                   out_last
);

  localparam int IW = SA_DRAIN_IDX_W;

  sa_drain_state_e      state_q;
  logic [N_CNT-1:0]     rem_q;
  logic [3:0]           wait_q;
  logic                 snap_q, busy_q, done_q, vld_q, last_q;
  sa_drain_beat_t       data_q;

  logic [N_CNT-1:0]     eff_mask, pri_clr, rem_ld_d, rem_hold_d;
  logic [IW-1:0]        pri_idx;
  logic                 pri_found, ld, last_d;
  sa_drain_beat_t       beat_d;

`ifdef CR_CCEIP_64_SA_DRAIN_SKIP_ZERO_EN
  logic [N_CNT-1:0]     nz_vec, low_mask;

  for (genvar g = 0; g < N_CNT; g++) begin : g_nz
    assign nz_vec[g] = |sa_snapshot[g*CNT_W +: CNT_W];
  end

  assign eff_mask = rem_q & nz_vec;
  // Bits 0..idx: the chosen bit plus any zero-valued counters below it.
  assign low_mask   = ~(({N_CNT{1'b1}} << pri_idx) << 1);
  assign rem_ld_d   = rem_q & ~low_mask;
  assign rem_hold_d = (eff_mask == '0) ? '0 : rem_q;
`else
  assign eff_mask   = rem_q;
  assign rem_ld_d   = pri_clr;
  assign rem_hold_d = rem_q;
`endif

  cr_cceip_64_sa_drain_pri #(.W(N_CNT)) u_pri (
    .mask_i  (eff_mask),
    .idx_o   (pri_idx),
    .found_o (pri_found),
    .clr_o   (pri_clr)
  );

  // Next beat: lowest selected counter, sampled straight from the snapshot.
  always_comb begin
    beat_d       = '0;
    beat_d.mid   = module_id;
    beat_d.idx   = pri_idx;
    beat_d.value = sa_snapshot[32'(pri_idx)*CNT_W +: CNT_W];
  end

  assign ld     = (state_q == STREAM) && (!vld_q || out_ready) && pri_found;
  assign last_d = (pri_clr == '0);

  // Drain FSM with registered strobes and the single-entry output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      wait_q  <= '0;
      snap_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      snap_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (drain_start) begin
            rem_q   <= drain_mask;
            busy_q  <= 1'b1;
            snap_q  <= 1'b1;
            state_q <= SNAP;
          end
        end
        SNAP: begin
          wait_q  <= 4'(SNAP_LAT - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (wait_q == 4'd0) state_q <= STREAM;
          else                wait_q  <= wait_q - 4'd1;
        end
        STREAM: begin
          if (ld) begin
            vld_q  <= 1'b1;
            data_q <= beat_d;
            last_q <= last_d;
            rem_q  <= rem_ld_d;
          end else begin
            if (vld_q && out_ready) vld_q <= 1'b0;
            rem_q <= rem_hold_d;
          end
          if (!pri_found && (!vld_q || out_ready)) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sa_snap    = snap_q;
  assign drain_busy = busy_q;
  assign drain_done = done_q;
  assign start_drop = !rst && drain_start && (state_q != IDLE);
  assign out_valid  = vld_q;
  assign out_data   = data_q;
  assign out_last   = last_q;

endmodule

// File: tb/tb_cr_cceip_64_sa_drain.sv
// Directed bench for the stats aggregator drain block.
module tb_cr_cceip_64_sa_drain;

  localparam int N  = 64;
  localparam int CW = 50;
  localparam int SL = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            drain_start;
  logic [N-1:0]    drain_mask;
  logic [7:0]      module_id;
  logic [N*CW-1:0] sa_snapshot;
  logic            sa_snap, drain_busy, drain_done, start_drop;
  logic            out_valid, out_ready, out_last;
  logic [63:0]     out_data;

  cr_cceip_64_sa_drain #(.SNAP_LAT(SL)) dut (
    .clk(clk), .rst(rst), .drain_start(drain_start), .drain_mask(drain_mask),
    .module_id(module_id), .sa_snapshot(sa_snapshot), .sa_snap(sa_snap),
    .drain_busy(drain_busy), .drain_done(drain_done), .start_drop(start_drop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Per-drain observations
  logic [63:0] bdata[$];
  logic        blast[$];
  int          bcyc[$];
  int          snaps, snap_cyc, dones, busyw, first, stall_err, drops, timeout;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setv(input int i, input logic [CW-1:0] v);
    sa_snapshot[i*CW +: CW] = v;
  endtask

  function automatic logic [63:0] mkbeat(input logic [7:0] m, input int i, input logic [CW-1:0] v);
    logic [5:0] ix;
    ix = 6'(i);
    return {m, ix, v};
  endfunction

  // Run one drain from start to return-to-idle, recording what is seen.
  // toggle: out_ready alternates 0/1; poke: fire drain_start at the first
  // valid beat and in the done cycle.
  task automatic drain(input logic [N-1:0] mask, input bit toggle, input bit poke);
    int n;
    bit seen_done, held;
    logic [63:0] pd;
    logic        pl;
    bdata.delete(); blast.delete(); bcyc.delete();
    snaps = 0; snap_cyc = -1; dones = 0; busyw = 0; first = -1;
    stall_err = 0; drops = 0; timeout = 0;
    seen_done = 0; held = 0; pd = '0; pl = 0;
    drain_mask  = mask;
    drain_start = 1'b1;
    cyc();
    drain_start = 1'b0;
    n = 1;
    while (!(seen_done && !drain_busy)) begin
      if (n > 300) begin timeout = 1; break; end
      out_ready = toggle ? n[0] : 1'b1;
      if (sa_snap) begin snaps++; if (snap_cyc < 0) snap_cyc = n; end
      if (drain_busy) busyw++;
      if (held && (!out_valid || out_data !== pd || out_last !== pl)) stall_err++;
      if (out_valid && first < 0) first = n;
      if (poke && ((out_valid && n == first) || drain_done)) begin
        drain_start = 1'b1;
        #1;
        if (start_drop) drops++;
      end
      if (drain_done) begin dones++; seen_done = 1; end
      if (out_valid && out_ready) begin
        bdata.push_back(out_data); blast.push_back(out_last); bcyc.push_back(n);
      end
      held = out_valid && !out_ready;
      pd = out_data; pl = out_last;
      cyc();
      drain_start = 1'b0;
      n++;
    end
    out_ready = 1'b1;
  endtask

  logic [CW-1:0] v0, v4, v63;

  initial begin
    rst = 1'b1; drain_start = 1'b0; drain_mask = '0; module_id = 8'hA5;
    sa_snapshot = '0; out_ready = 1'b1;
    v0  = 50'h3_FFFF_FFFF_FFFF;
    v4  = 50'h1_2345_6789_ABCD;
    v63 = 50'h0_0000_0000_0042;
    cyc(); cyc();
    chk("reset_outs", {57'd0, sa_snap, drain_busy, drain_done, start_drop, out_valid, out_last}, 64'd0);
    chk("reset_data", out_data, 64'd0);
    rst = 1'b0;
    cyc();

    // Single counter, full-scale value
    setv(0, v0);
    drain(64'h1, 0, 0);
    chk("t1_timeout", 64'(timeout), 64'd0);
    chk("t1_snap_cyc", 64'(snap_cyc), 64'd1);
    chk("t1_snaps", 64'(snaps), 64'd1);
    chk("t1_nbeats", 64'(bdata.size()), 64'd1);
    if (bdata.size() == 1) begin
      chk("t1_data", bdata[0], mkbeat(8'hA5, 0, v0));
      chk("t1_last", 64'(blast[0]), 64'd1);
    end
    chk("t1_first_ge", 64'(first >= 2 + SL), 64'd1);
    chk("t1_dones", 64'(dones), 64'd1);
    chk("t1_idle", {62'd0, drain_busy, out_valid}, 64'd0);

    // Three sparse counters, ready always high
    setv(4, v4); setv(63, v63);
    drain(64'h8000_0000_0000_0011, 0, 0);
    chk("t2_nbeats", 64'(bdata.size()), 64'd3);
    if (bdata.size() == 3) begin
      chk("t2_b0", bdata[0], mkbeat(8'hA5, 0, v0));
      chk("t2_b1", bdata[1], mkbeat(8'hA5, 4, v4));
      chk("t2_b2", bdata[2], mkbeat(8'hA5, 63, v63));
      chk("t2_lasts", {61'd0, blast[0], blast[1], blast[2]}, 64'd1);
      chk("t2_consec", 64'((bcyc[1] == bcyc[0] + 1) && (bcyc[2] == bcyc[1] + 1)), 64'd1);
    end
    chk("t2_dones", 64'(dones), 64'd1);

    // Same mask with backpressure
    module_id = 8'h3C;
    drain(64'h8000_0000_0000_0011, 1, 0);
    chk("t3_timeout", 64'(timeout), 64'd0);
    chk("t3_nbeats", 64'(bdata.size()), 64'd3);
    chk("t3_stall", 64'(stall_err), 64'd0);
    if (bdata.size() == 3) begin
      chk("t3_b0", bdata[0], mkbeat(8'h3C, 0, v0));
      chk("t3_b1", bdata[1], mkbeat(8'h3C, 4, v4));
      chk("t3_b2", bdata[2], mkbeat(8'h3C, 63, v63));
      chk("t3_lasts", {61'd0, blast[0], blast[1], blast[2]}, 64'd1);
    end
    chk("t3_dones", 64'(dones), 64'd1);

    // Empty mask
    drain(64'h0, 0, 0);
    chk("t4_snaps", 64'(snaps), 64'd1);
    chk("t4_novalid", 64'(first), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t4_dones", 64'(dones), 64'd1);
    chk("t4_busyw", 64'(busyw), 64'(2 + SL + 1));

    // Starts while busy are dropped, drain unaffected
    module_id = 8'hA5;
    drain(64'h8000_0000_0000_0011, 0, 1);
    chk("t5_drops", 64'(drops), 64'd2);
    chk("t5_snaps", 64'(snaps), 64'd1);
    chk("t5_nbeats", 64'(bdata.size()), 64'd3);
    chk("t5_dones", 64'(dones), 64'd1);
    cyc(); cyc();
    chk("t5_no_restart", {62'd0, drain_busy, sa_snap}, 64'd0);

    // Reset mid-stream
    out_ready = 1'b0;
    drain_mask = 64'h11; drain_start = 1'b1;
    cyc();
    drain_start = 1'b0;
    for (int k = 0; k < 20 && !out_valid; k++) cyc();
    chk("t6_valid_before_rst", 64'(out_valid), 64'd1);
    rst = 1'b1;
    cyc();
    chk("t6_rst_outs", {57'd0, sa_snap, drain_busy, drain_done, start_drop, out_valid, out_last}, 64'd0);
    chk("t6_rst_data", out_data, 64'd0);
    rst = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    chk("t6_quiet", {62'd0, out_valid, drain_done}, 64'd0);
    drain(64'h1, 0, 0);
    chk("t6_restart_nbeats", 64'(bdata.size()), 64'd1);
    if (bdata.size() == 1) chk("t6_restart_data", bdata[0], mkbeat(8'hA5, 0, v0));
    chk("t6_restart_dones", 64'(dones), 64'd1);

    // Zero-valued counters
    setv(0, '0); setv(1, 50'd5); setv(2, '0); setv(3, 50'd7);
`ifdef CR_CCEIP_64_SA_DRAIN_SKIP_ZERO_EN
    drain(64'hF, 0, 0);
    chk("t7_nbeats", 64'(bdata.size()), 64'd2);
    if (bdata.size() == 2) begin
      chk("t7_b0", bdata[0], mkbeat(8'hA5, 1, 50'd5));
      chk("t7_b1", bdata[1], mkbeat(8'hA5, 3, 50'd7));
      chk("t7_lasts", {62'd0, blast[0], blast[1]}, 64'd1);
    end
    chk("t7_dones", 64'(dones), 64'd1);
    drain(64'h5, 0, 0);
    chk("t8_allzero_nbeats", 64'(bdata.size()), 64'd0);
    chk("t8_allzero_dones", 64'(dones), 64'd1);
`else
    drain(64'hF, 0, 0);
    chk("t7_nbeats", 64'(bdata.size()), 64'd4);
    if (bdata.size() == 4) begin
      chk("t7_b0", bdata[0], mkbeat(8'hA5, 0, 50'd0));
      chk("t7_b1", bdata[1], mkbeat(8'hA5, 1, 50'd5));
      chk("t7_b2", bdata[2], mkbeat(8'hA5, 2, 50'd0));
      chk("t7_b3", bdata[3], mkbeat(8'hA5, 3, 50'd7));
      chk("t7_lasts", {60'd0, blast[0], blast[1], blast[2], blast[3]}, 64'd1);
    end
    chk("t7_dones", 64'(dones), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
